// File: rtl/rca_seq_pkg.sv
// Shared types and constants for the nibble-serial ripple-carry adder sequencer.
package rca_seq_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} rca_seq_state_t;

  localparam int SLICE_W = 4;

  // Nibble index width; a single-nibble build still needs a one-bit counter.
  function automatic int idxWidth(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// Plain ripple-carry adder slice built from a chain of full adders.
module ripple_carry_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  logic [WIDTH:0] w_carry;

  assign w_carry[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign Sum[i]       = A[i] ^ B[i] ^ w_carry[i];
    assign w_carry[i+1] = (A[i] & B[i]) | (w_carry[i] & (A[i] ^ B[i]));
  end

  assign Cout = w_carry[WIDTH];

endmodule

// File: rtl/rca_nibble_sequencer.sv
// Wide adder that reuses one 4-bit ripple-carry slice, one nibble per clock, LSB first.
// Optional subtract mode (sub port) is built when RCA_SEQ_SUB_EN is defined.
module rca_nibble_sequencer
  import rca_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef RCA_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / SLICE_W;
  localparam int IDX_W   = idxWidth(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  if ((WIDTH < SLICE_W) || ((WIDTH % SLICE_W) != 0)) begin : g_bad_width
    $error("rca_nibble_sequencer: WIDTH must be a multiple of 4 and at least 4");
  end

  rca_seq_state_t     r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic               r_cout;
  logic               r_inReady;
  logic               r_outValid;
  logic               r_busy;

  logic [WIDTH-1:0]   w_bLatch;
  logic               w_carryIn;
  logic [SLICE_W-1:0] w_aNib;
  logic [SLICE_W-1:0] w_bNib;
  logic [SLICE_W-1:0] w_sliceSum;
  logic               w_sliceCout;

  // Subtraction is a + ~b + 1, so the carry-in is forced and cin is ignored.
`ifdef RCA_SEQ_SUB_EN
  assign w_bLatch  = sub ? ~b : b;
  assign w_carryIn = sub ? 1'b1 : cin;
`else
  assign w_bLatch  = b;
  assign w_carryIn = cin;
`endif

  assign w_aNib = r_a[int'(r_idx)*SLICE_W +: SLICE_W];
  assign w_bNib = r_b[int'(r_idx)*SLICE_W +: SLICE_W];

  ripple_carry_adder #(
    .WIDTH(SLICE_W)
  ) u_slice (
    .A   (w_aNib),
    .B   (w_bNib),
    .Cin (r_carry),
    .Sum (w_sliceSum),
    .Cout(w_sliceCout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_sum      <= '0;
      r_idx      <= '0;
      r_carry    <= 1'b0;
      r_cout     <= 1'b0;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_inReady) begin
            r_a       <= a;
            r_b       <= w_bLatch;
            r_carry   <= w_carryIn;
            r_idx     <= '0;
            r_sum     <= '0;
            r_inReady <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= BUSY;
          end
        end
        BUSY: begin
          r_sum[int'(r_idx)*SLICE_W +: SLICE_W] <= w_sliceSum;
          r_carry <= w_sliceCout;
          if (r_idx == LAST_IDX) begin
            r_cout     <= w_sliceCout;
            r_outValid <= 1'b1;
            r_state    <= DONE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        DONE: begin
          // Result stays parked here until the consumer takes it.
          if (out_ready) begin
            r_outValid <= 1'b0;
            r_busy     <= 1'b0;
            r_inReady  <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_inReady  <= 1'b1;
          r_outValid <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign busy      = r_busy;
  assign sum       = r_sum;
  assign cout      = r_cout;

endmodule
